// File: rtl/hms_timekeeper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hms_pkg
// Purpose  : Shared types and constants for the hms_timekeeper block.
//            The optional alarm feature is enabled with HMS_ALARM_EN.
// Revision : 1.0  initial release
// ============================================================================
package hms_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  // Increment with wrap to zero once the field has reached its maximum.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hms_timekeeper_if.sv
`default_nettype none
// ============================================================================
// Module   : hms_timekeeper_if
// Purpose  : Switch inputs and time/status outputs of the timekeeper.
//            o_alarm exists only when HMS_ALARM_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface hms_timekeeper_if;
  import hms_pkg::*;

  logic              i_sw_mode;
  logic              i_sw_pos;
  logic              i_sw_inc;
  logic [SEC_W-1:0]  o_sec;
  logic [MIN_W-1:0]  o_min;
  logic [HOUR_W-1:0] o_hour;
  logic [1:0]        o_mode;
  logic [1:0]        o_position;
  logic              o_blink;
  logic              o_tick;
`ifdef HMS_ALARM_EN
  logic              o_alarm;
`endif

  modport master (
    output i_sw_mode, i_sw_pos, i_sw_inc,
    input  o_sec, o_min, o_hour, o_mode, o_position, o_blink, o_tick
`ifdef HMS_ALARM_EN
    , input o_alarm
`endif
  );

  modport slave (
    input  i_sw_mode, i_sw_pos, i_sw_inc,
    output o_sec, o_min, o_hour, o_mode, o_position, o_blink, o_tick
`ifdef HMS_ALARM_EN
    , output o_alarm
`endif
  );

endinterface
`default_nettype wire

// File: rtl/hms_timekeeper_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : hms_edge_sync
// Purpose  : Two-flop synchroniser followed by a registered rising-edge
//            pulse. The pulse is visible after the 2nd clk edge following
//            the input rise, so dependent logic acts on the 3rd edge.
// Revision : 1.0  initial release
// ============================================================================
module hms_edge_sync (
  input  wire  clk,
  input  wire  rst,
  input  wire  din,
  output logic rise
);

  logic s1;
  logic s2;

  // Synchronise the level and flag a 0->1 transition for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= s1 & ~s2;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hms_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : hms_timekeeper
// Purpose  : Single-clock hour:minute:second timekeeper with prescaled tick,
//            setup mode with field cursor and display blink strobe.
//            Define HMS_ALARM_EN to add the ALARM mode and o_alarm output.
// Revision : 1.0  initial release
// ============================================================================
module hms_timekeeper
  import hms_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int HOUR_MAX = 23
) (
  input wire               clk,
  input wire               rst,
  hms_timekeeper_if.slave  bus
);

  localparam int TC = CLK_HZ / TICK_HZ - 1;
  localparam int PW = $clog2(TC + 1);
  localparam logic [PW-1:0]     PRESC_TC = PW'(TC);
  localparam logic [PW-1:0]     HALF     = PW'((TC + 1) / 2);
  localparam logic [HOUR_W-1:0] HOUR_LIM = HOUR_W'(HOUR_MAX);

  logic mode_rise, pos_rise, inc_rise;

  hms_edge_sync u_sync_mode (.clk(clk), .rst(rst), .din(bus.i_sw_mode), .rise(mode_rise));
  hms_edge_sync u_sync_pos  (.clk(clk), .rst(rst), .din(bus.i_sw_pos),  .rise(pos_rise));
  hms_edge_sync u_sync_inc  (.clk(clk), .rst(rst), .din(bus.i_sw_inc),  .rise(inc_rise));

  mode_t             mode, mode_n;
  pos_t              pos;
  logic [PW-1:0]     presc, presc_n;
  logic              tick, blink, leave_clear;
  logic [SEC_W-1:0]  sec, sec_inc;
  logic [MIN_W-1:0]  min, min_inc;
  logic [HOUR_W-1:0] hour, hour_inc;
  logic              sec_wrap, min_wrap;

  assign sec_inc  = inc_wrap(sec, SEC_MAX);
  assign min_inc  = inc_wrap(min, MIN_MAX);
  assign hour_inc = (hour >= HOUR_LIM) ? '0 : hour + 5'd1;
  assign sec_wrap = (sec == SEC_MAX);
  assign min_wrap = (min == MIN_MAX);

`ifdef HMS_ALARM_EN
  logic [MIN_W-1:0]  al_min, al_min_inc;
  logic [HOUR_W-1:0] al_hour, al_hour_inc;
  logic [5:0]        al_cnt;
  logic              alarm, al_match;

  assign al_min_inc  = inc_wrap(al_min, MIN_MAX);
  assign al_hour_inc = (al_hour >= HOUR_LIM) ? '0 : al_hour + 5'd1;
  // Time after this tick lands exactly on alarm hh:mm:00.
  assign al_match = sec_wrap
                 && ((min_wrap ? '0 : min_inc) == al_min)
                 && (((min_wrap) ? hour_inc : hour) == al_hour);
  assign bus.o_alarm = alarm;
`endif

  // Next mode and prescaler value; returning to CLOCK restarts the second.
  always_comb begin
    mode_n      = mode;
    leave_clear = 1'b0;
    if (mode_rise) begin
      case (mode)
        MODE_CLOCK: mode_n = MODE_SETUP;
`ifdef HMS_ALARM_EN
        MODE_SETUP: mode_n = MODE_ALARM;
`endif
        default: begin
          mode_n      = MODE_CLOCK;
          leave_clear = 1'b1;
        end
      endcase
    end
    presc_n = (leave_clear || presc == PRESC_TC) ? '0 : presc + 1'b1;
  end

  // Mode FSM, cursor, time counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= MODE_CLOCK;
      pos   <= POS_SEC;
      presc <= '0;
      tick  <= 1'b0;
      blink <= 1'b0;
      sec   <= '0;
      min   <= '0;
      hour  <= '0;
    end else begin
      mode  <= mode_n;
      presc <= presc_n;
      tick  <= ~leave_clear & (presc == PRESC_TC);
      blink <= (mode_n != MODE_CLOCK) && (presc_n < HALF);
      if (mode_rise) begin
        if (mode_n == MODE_SETUP) pos <= POS_SEC;
`ifdef HMS_ALARM_EN
        else if (mode_n == MODE_ALARM) pos <= POS_MIN;
`endif
      end else if (mode == MODE_CLOCK) begin
        if (tick) begin
          sec <= sec_inc;
          if (sec_wrap) min <= min_inc;
          if (sec_wrap && min_wrap) hour <= hour_inc;
        end
      end else if (pos_rise) begin
        case (pos)
          POS_SEC: pos <= POS_MIN;
          POS_MIN: pos <= POS_HOUR;
          default: begin
`ifdef HMS_ALARM_EN
            pos <= (mode == MODE_ALARM) ? POS_MIN : POS_SEC;
`else
            pos <= POS_SEC;
`endif
          end
        endcase
      end else if (inc_rise) begin
`ifdef HMS_ALARM_EN
        if (mode == MODE_ALARM) begin
          if (pos == POS_HOUR) al_hour <= al_hour_inc;
          else                 al_min  <= al_min_inc;
        end else
`endif
        begin
          case (pos)
            POS_SEC: sec  <= sec_inc;
            POS_MIN: min  <= min_inc;
            default: hour <= hour_inc;
          endcase
        end
      end
    end
  end

`ifdef HMS_ALARM_EN
  // Alarm flag: set on matching tick, cleared by any switch edge or 60 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm   <= 1'b0;
      al_cnt  <= '0;
      al_min  <= '0;
      al_hour <= '0;
    end else if (mode_rise || pos_rise || inc_rise) begin
      alarm <= 1'b0;
    end else if (mode == MODE_CLOCK && tick) begin
      if (alarm) begin
        if (al_cnt == 6'd59) alarm <= 1'b0;
        al_cnt <= al_cnt + 6'd1;
      end else if (al_match) begin
        alarm  <= 1'b1;
        al_cnt <= '0;
      end
    end
  end
`endif

  assign bus.o_sec      = sec;
  assign bus.o_min      = min;
  assign bus.o_hour     = hour;
  assign bus.o_mode     = mode;
  assign bus.o_position = pos;
  assign bus.o_blink    = blink;
  assign bus.o_tick     = tick;

endmodule
`default_nettype wire
